// File: rtl/bp_fe_bht_ctrl.sv
// BHT port controller: sweeps the counter RAM to weakly-not-taken after reset,
// then arbitrates one RAM port between prediction reads and queued counter updates.
module bp_fe_bht_ctrl #(
  parameter int unsigned bht_idx_width_p = 9,
  parameter int unsigned wq_els_p        = 2,
  parameter int unsigned starve_limit_p  = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  output logic                       init_done_o,
  input  logic                       r_v_i,
  input  logic [bht_idx_width_p-1:0] r_idx_i,
  output logic                       r_ready_o,
  output logic                       r_v_o,
  output logic [1:0]                 r_cnt_o,
  input  logic                       w_v_i,
  input  logic [bht_idx_width_p-1:0] w_idx_i,
  input  logic [1:0]                 w_cnt_i,
  input  logic                       w_taken_i,
  output logic                       w_ready_o,
  output logic                       mem_v_o,
  output logic                       mem_w_o,
  output logic [bht_idx_width_p-1:0] mem_addr_o,
  output logic [1:0]                 mem_data_o,
  input  logic [1:0]                 mem_data_i
);

  localparam int unsigned idx_w_lp = bht_idx_width_p;
  localparam int unsigned cnt_w_lp = $clog2(wq_els_p + 1);
  localparam int unsigned st_w_lp  = $clog2(starve_limit_p + 1);

  typedef enum logic {e_init, e_run} state_e;

  state_e                r_state;
  logic [idx_w_lp-1:0]   r_init_cnt;
  logic                  r_init_done;
  logic [idx_w_lp-1:0]   r_q_idx [wq_els_p];
  logic [1:0]            r_q_cnt [wq_els_p];
  logic [cnt_w_lp-1:0]   r_q_count;
  logic [st_w_lp-1:0]    r_starve;
  logic                  r_rd_v;
  logic                  r_byp_v;
  logic [1:0]            r_byp_cnt;

  logic                  w_run, w_q_empty, w_q_full, w_force;
  logic                  w_rd_go, w_wr_go, w_enq;
  logic [1:0]            w_next_cnt;
  logic [cnt_w_lp-1:0]   w_enq_slot;
  logic                  w_byp_hit;
  logic [1:0]            w_byp_val;

  assign w_run     = (r_state == e_run);
  assign w_q_empty = (r_q_count == '0);
  assign w_q_full  = (r_q_count == cnt_w_lp'(wq_els_p));
  assign w_force   = w_run && !w_q_empty && (r_starve == st_w_lp'(starve_limit_p));
  assign w_rd_go   = w_run && !w_force && r_v_i;
  assign w_wr_go   = w_run && !w_q_empty && (w_force || !r_v_i);
  assign w_enq     = w_v_i && w_ready_o;
  assign w_enq_slot = w_wr_go ? (r_q_count - cnt_w_lp'(1)) : r_q_count;

  assign init_done_o = r_init_done;
  assign r_ready_o   = r_init_done && !w_force;
  assign w_ready_o   = r_init_done && !w_q_full;
  assign r_v_o       = r_rd_v;
  assign r_cnt_o     = r_rd_v ? (r_byp_v ? r_byp_cnt : mem_data_i) : 2'b00;

  // 2-bit saturating counter step
  always_comb begin
    w_next_cnt = w_cnt_i;
    if (w_taken_i) begin
      if (w_cnt_i != 2'b11) w_next_cnt = w_cnt_i + 2'b01;
    end else begin
      if (w_cnt_i != 2'b00) w_next_cnt = w_cnt_i - 2'b01;
    end
  end

  // Youngest live queue entry matching the read index; a head popped this cycle is already gone
  always_comb begin
    w_byp_hit = 1'b0;
    w_byp_val = 2'b00;
    for (int i = 0; i < int'(wq_els_p); i++) begin
      if ((i < int'(r_q_count)) && !(w_wr_go && (i == 0)) && (r_q_idx[i] == r_idx_i)) begin
        w_byp_hit = 1'b1;
        w_byp_val = r_q_cnt[i];
      end
    end
  end

  always_comb begin
    mem_v_o    = 1'b0;
    mem_w_o    = 1'b0;
    mem_addr_o = '0;
    mem_data_o = 2'b00;
    if (r_state == e_init) begin
      mem_v_o    = 1'b1;
      mem_w_o    = 1'b1;
      mem_addr_o = r_init_cnt;
      mem_data_o = 2'b01;
    end else if (w_wr_go) begin
      mem_v_o    = 1'b1;
      mem_w_o    = 1'b1;
      mem_addr_o = r_q_idx[0];
      mem_data_o = r_q_cnt[0];
    end else if (w_rd_go) begin
      mem_v_o    = 1'b1;
      mem_addr_o = r_idx_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= e_init;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        e_init: begin
          r_init_cnt <= r_init_cnt + idx_w_lp'(1);
          if (r_init_cnt == '1) begin
            r_state     <= e_run;
            r_init_done <= 1'b1;
          end
        end
        default: r_state <= e_run;
      endcase
    end
  end

  // Shift queue: slot 0 is the head; a pop shifts down, an enqueue lands behind the last live slot
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_q_count <= '0;
      for (int i = 0; i < int'(wq_els_p); i++) begin
        r_q_idx[i] <= '0;
        r_q_cnt[i] <= 2'b00;
      end
    end else begin
      for (int i = 0; i < int'(wq_els_p); i++) begin
        if (w_enq && (int'(w_enq_slot) == i)) begin
          r_q_idx[i] <= w_idx_i;
          r_q_cnt[i] <= w_next_cnt;
        end else if (w_wr_go && (i < int'(wq_els_p) - 1)) begin
          r_q_idx[i] <= r_q_idx[i+1];
          r_q_cnt[i] <= r_q_cnt[i+1];
        end
      end
      case ({w_enq, w_wr_go})
        2'b10:   r_q_count <= r_q_count + cnt_w_lp'(1);
        2'b01:   r_q_count <= r_q_count - cnt_w_lp'(1);
        default: r_q_count <= r_q_count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_starve <= '0;
    end else if (w_q_empty || w_wr_go) begin
      r_starve <= '0;
    end else if (r_starve != st_w_lp'(starve_limit_p)) begin
      r_starve <= r_starve + st_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rd_v    <= 1'b0;
      r_byp_v   <= 1'b0;
      r_byp_cnt <= 2'b00;
    end else begin
      r_rd_v    <= w_rd_go;
      r_byp_v   <= w_rd_go && w_byp_hit;
      r_byp_cnt <= w_byp_val;
    end
  end

endmodule
